// File: rtl/spi_pixel_rx_pkg.sv
// Shared constants and types for the SPI pixel receiver.
// Default widths stand in for the shared parameters.svh values (MAX_PIXEL_BITS, PIXEL_WIDTH_OUT).
package spi_rx_pkg;

    localparam int DEF_MAX_PIXEL_BITS  = 24;
    localparam int DEF_PIXEL_WIDTH_OUT = 8;
    localparam int CNT_W               = $clog2(DEF_MAX_PIXEL_BITS + 1);

    typedef enum logic {IDLE, SHIFT} spi_rx_state_t;

endpackage

// File: rtl/spi_pixel_rx_if.sv
// Parallel pixel bus from the SPI receiver to the grayscale/Sobel pipeline.
// px_count_o exists only when SPI_RX_PX_COUNT_EN is defined.
interface spi_pixel_rx_if
    import spi_rx_pkg::*;
#(
    parameter int MAX_PIXEL_BITS = DEF_MAX_PIXEL_BITS
);

    logic [MAX_PIXEL_BITS-1:0] out_pixel_o;
    logic                      px_rdy_o;
    logic                      busy_o;
`ifdef SPI_RX_PX_COUNT_EN
    logic [15:0]               px_count_o;
`endif

`ifdef SPI_RX_PX_COUNT_EN
    modport master (output out_pixel_o, output px_rdy_o, output busy_o, output px_count_o);
    modport slave  (input  out_pixel_o, input  px_rdy_o, input  busy_o, input  px_count_o);
`else
    modport master (output out_pixel_o, output px_rdy_o, output busy_o);
    modport slave  (input  out_pixel_o, input  px_rdy_o, input  busy_o);
`endif

endinterface

// File: rtl/spi_pixel_rx_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, plus a history flop
// giving single-cycle rise/fall pulses in the clk_i domain.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI-style serial pixel receiver: packs MSB-first bits into RGB888 or gray words.
// Optional macro SPI_RX_PX_COUNT_EN adds a per-frame word counter (px_count_o).
module spi_pixel_rx
    import spi_rx_pkg::*;
#(
    parameter int MAX_PIXEL_BITS = DEF_MAX_PIXEL_BITS,
    parameter int GRAY_BITS      = DEF_PIXEL_WIDTH_OUT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           sclk_i,
    input  logic           cs_n_i,
    input  logic           mosi_i,
    input  logic           gray_mode_i,
    spi_pixel_rx_if.master px
);

    localparam int CW = $clog2(MAX_PIXEL_BITS + 1);

    logic sclk_rise, cs_fall, cs_rise, mosi_s;
    logic sclk_level_unused, sclk_fall_unused, cs_level_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(sclk_i),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(cs_n_i),
        .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk_i(clk_i), .reset_i(reset_i), .d_i(mosi_i),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_rx_state_t             state_q;
    logic                      mode_q;
    logic                      done_q;
    logic                      px_rdy_q;
    logic                      busy_q;
    logic [CW-1:0]             bit_cnt_q;
    logic [CW-1:0]             last_bit;
    logic [MAX_PIXEL_BITS-1:0] shreg_q;
    logic [MAX_PIXEL_BITS-1:0] out_q;
`ifdef SPI_RX_PX_COUNT_EN
    logic [15:0]               px_count_q;
`endif

    assign last_bit = mode_q ? CW'(GRAY_BITS - 1) : CW'(MAX_PIXEL_BITS - 1);

    // The word is captured one cycle after its last shift, so done_q bridges the two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            px_rdy_q  <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            out_q     <= '0;
`ifdef SPI_RX_PX_COUNT_EN
            px_count_q <= '0;
`endif
        end else begin
            px_rdy_q <= 1'b0;
            done_q   <= 1'b0;
            if (done_q) begin
                px_rdy_q <= 1'b1;
                out_q    <= mode_q ? MAX_PIXEL_BITS'(shreg_q[GRAY_BITS-1:0]) : shreg_q;
`ifdef SPI_RX_PX_COUNT_EN
                if (px_count_q != 16'hFFFF)
                    px_count_q <= px_count_q + 16'd1;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        mode_q    <= gray_mode_i;
`ifdef SPI_RX_PX_COUNT_EN
                        px_count_q <= '0;
`endif
                    end
                end
                SHIFT: begin
                    // Frame end takes priority over a coincident sclk edge.
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise) begin
                        shreg_q <= {shreg_q[MAX_PIXEL_BITS-2:0], mosi_s};
                        if (bit_cnt_q == last_bit) begin
                            bit_cnt_q <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign px.out_pixel_o = out_q;
    assign px.px_rdy_o    = px_rdy_q;
    assign px.busy_o      = busy_q;
`ifdef SPI_RX_PX_COUNT_EN
    assign px.px_count_o  = px_count_q;
`endif

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Self-checking bench for spi_pixel_rx: vector table, hand-written corner
// sequences, and random frames checked against expected word lists.
module tb_spi_pixel_rx;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;

    logic clk = 1'b0;
    logic reset_i, sclk_i, cs_n_i, mosi_i, gray_mode_i;

    spi_pixel_rx_if #(.MAX_PIXEL_BITS(24)) px_if ();

    spi_pixel_rx #(.MAX_PIXEL_BITS(24), .GRAY_BITS(8), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i(clk), .reset_i(reset_i), .sclk_i(sclk_i), .cs_n_i(cs_n_i),
        .mosi_i(mosi_i), .gray_mode_i(gray_mode_i), .px(px_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_bad = 0;
    int dbl_cnt = 0;
    int last_rise_cyc = 0;
    logic prev_rdy = 1'b0;
    logic [23:0] obs_q[$];
    int          obs_cyc[$];
    logic [23:0] exp_q[$];
    bit          tx_bits[$];
    logic [23:0] model_out = '0;

    always @(negedge clk) begin
        if (px_if.px_rdy_o === 1'b1) begin
            obs_q.push_back(px_if.out_pixel_o);
            obs_cyc.push_back(cyc);
            if (prev_rdy === 1'b1) dbl_cnt++;
        end
        prev_rdy = px_if.px_rdy_o;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [23:0] w, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) tx_bits.push_back(w[b]);
    endtask

    task automatic shift_bits(input bit gray, input int flip_at, input bit coll);
        for (int i = 0; i < tx_bits.size(); i++) begin
            mosi_i = tx_bits[i];
            sclk_i = 1'b0;
            ticks(4);
            if (i == flip_at) gray_mode_i = ~gray;
            sclk_i = 1'b1;
            if (coll && i == tx_bits.size() - 1) cs_n_i = 1'b1;
            last_rise_cyc = cyc;
            ticks(4);
        end
        sclk_i = 1'b0;
    endtask

    task automatic play_frame(input bit gray, input int flip_at, input bit coll);
        gray_mode_i = gray;
        cs_n_i = 1'b0;
        ticks(6);
        check("busy in frame", 32'(px_if.busy_o), 32'd1);
        shift_bits(gray, flip_at, coll);
        ticks(4);
        cs_n_i = 1'b1;
        ticks(8);
        tx_bits.delete();
    endtask

    task automatic check_frame(input string tag);
        check({tag, " strobes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, " word"}, (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hxxxxxxxx, 32'(exp_q[i]));
        if (exp_q.size() > 0) model_out = exp_q[exp_q.size() - 1];
        check({tag, " hold"}, 32'(px_if.out_pixel_o), 32'(model_out));
        check({tag, " busy after"}, 32'(px_if.busy_o), 32'd0);
`ifdef SPI_RX_PX_COUNT_EN
        check({tag, " px_count"}, 32'(px_if.px_count_o), 32'(exp_q.size()));
`endif
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    typedef struct {
        bit          gray;
        int          nbits;
        logic [23:0] data;
        int          flip_at;
        bit          coll;
        int          exp_n;
        logic [23:0] exp_px;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 24, 24'hA5C3F0, -1, 1'b0, 1, 24'hA5C3F0};
        vecs[1] = '{1'b1,  8, 24'h000012, -1, 1'b0, 1, 24'h000012};
        vecs[2] = '{1'b0, 13, 24'h001ABC, -1, 1'b0, 0, 24'h000012};
        vecs[3] = '{1'b0, 24, 24'h010203, -1, 1'b0, 1, 24'h010203};
        vecs[4] = '{1'b0, 24, 24'h123456, -1, 1'b1, 0, 24'h010203};
        vecs[5] = '{1'b0, 24, 24'h7F7F7F,  4, 1'b0, 1, 24'h7F7F7F};
        vecs[6] = '{1'b1,  8, 24'h0000FE,  3, 1'b0, 1, 24'h0000FE};

        reset_i = 1'b1; cs_n_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; gray_mode_i = 1'b0;

        // Reset held 3 cycles with sclk toggling.
        ticks(1);
        for (int i = 0; i < 3; i++) begin
            sclk_i = ~sclk_i;
            ticks(1);
            check("reset out_pixel", 32'(px_if.out_pixel_o), 32'd0);
            check("reset px_rdy", 32'(px_if.px_rdy_o), 32'd0);
            check("reset busy", 32'(px_if.busy_o), 32'd0);
        end
        reset_i = 1'b0;
        sclk_i = 1'b0;
        ticks(12);
        check("no strobe after reset", 32'(obs_q.size()), 32'd0);

        for (int v = 0; v < 7; v++) begin
            push_word(vecs[v].data, vecs[v].nbits);
            play_frame(vecs[v].gray, vecs[v].flip_at, vecs[v].coll);
            if (vecs[v].exp_n == 1 && obs_cyc.size() > 0)
                check($sformatf("vec%0d latency", v), 32'(obs_cyc[0] - last_rise_cyc), 32'(LAT));
            if (vecs[v].exp_n == 1) exp_q.push_back(vecs[v].exp_px);
            check_frame($sformatf("vec%0d", v));
        end

        // Back-to-back gray words in a single frame.
        push_word(24'h12, 8);
        push_word(24'hFE, 8);
        push_word(24'h00, 8);
        play_frame(1'b1, -1, 1'b0);
        exp_q.push_back(24'h000012);
        exp_q.push_back(24'h0000FE);
        exp_q.push_back(24'h000000);
        check_frame("gray burst");

        // Reset in the middle of a word discards it and clears the output.
        gray_mode_i = 1'b0;
        cs_n_i = 1'b0;
        ticks(6);
        push_word(24'h2AB, 10);
        shift_bits(1'b0, -1, 1'b0);
        tx_bits.delete();
        reset_i = 1'b1;
        cs_n_i = 1'b1;
        ticks(3);
        check("midword reset out_pixel", 32'(px_if.out_pixel_o), 32'd0);
        check("midword reset busy", 32'(px_if.busy_o), 32'd0);
        reset_i = 1'b0;
        ticks(12);
        check("midword reset strobes", 32'(obs_q.size()), 32'd0);
        model_out = '0;

        // Random frames: whole words plus an optional partial tail, random mode flips.
        for (int f = 0; f < 25; f++) begin
            bit          g;
            int          nw, len, tail, flip;
            logic [23:0] w;
            g    = 1'($urandom_range(0, 1));
            len  = g ? 8 : 24;
            nw   = $urandom_range(1, 3);
            tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
            flip = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nw * len - 1) : -1;
            for (int k = 0; k < nw; k++) begin
                w = 24'($urandom);
                if (g) w = {16'h0000, w[7:0]};
                push_word(w, len);
                exp_q.push_back(w);
            end
            push_word(24'($urandom), tail);
            play_frame(g, flip, 1'b0);
            check_frame($sformatf("rand%0d", f));
        end

        check("single-cycle strobe", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
